// File: rtl/cl_mult_seq.sv
// Sequential carry-less (GF(2)[x]) multiplier: one multiplier bit per clock,
// producing an unreduced 2*DATA_WIDTH product for a downstream reduction stage.
module cl_mult_seq #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          start,
    input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
    input  logic [DATA_WIDTH-1:0]         a,
    input  logic [DATA_WIDTH-1:0]         b,
    output logic                          busy,
    output logic                          done,
    output logic [2*DATA_WIDTH-1:0]       prod
);

    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [PW-1:0]        a_sh_r;
    logic [DATA_WIDTH-1:0] b_sh_r;
    logic [PW-1:0]        acc_r;
    logic [GW-1:0]        cnt_r;
    logic [GW-1:0]        grade_r;
    logic                 busy_r;
    logic                 done_r;
    logic [PW-1:0]        prod_r;

    logic                 accept_s;
    logic                 grade_ok_s;
    logic                 last_s;
    logic [PW-1:0]        acc_step_s;
    logic                 busy_s;
    logic                 done_s;
    logic [PW-1:0]        prod_s;

    // Keeps only coefficients below the field degree g.
    function automatic logic [DATA_WIDTH-1:0] grade_mask(input logic [GW-1:0] g);
        logic [DATA_WIDTH-1:0] m;
        m = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(g)) m[i] = 1'b1;
            else             m[i] = 1'b0;
        end
        return m;
    endfunction

    assign grade_ok_s = (polyn_grade >= GW'(2)) && (polyn_grade <= GW'(DATA_WIDTH));
    assign accept_s   = enable && start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s     = (cnt_r == (grade_r - GW'(1)));
    assign acc_step_s = b_sh_r[0] ? (acc_r ^ a_sh_r) : acc_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state logic; enable low overrides everything, including start.
    always_comb begin
        state_s = state_r;
        if (!enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) state_s = grade_ok_s ? RUN : DONE;
                    else       state_s = IDLE;
                end
                RUN: begin
                    if (last_s) state_s = DONE;
                    else        state_s = RUN;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; prod only moves on completion or clear.
    always_comb begin
        busy_s = (state_s == RUN);
        done_s = (state_s == DONE);
        prod_s = prod_r;
        if (!enable) begin
            busy_s = 1'b0;
            done_s = 1'b0;
            prod_s = {PW{1'b0}};
        end else if (accept_s && !grade_ok_s) begin
            prod_s = {PW{1'b0}};
        end else if ((state_r == RUN) && last_s) begin
            prod_s = acc_step_s;
        end else begin
            prod_s = prod_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            prod_r <= {PW{1'b0}};
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            prod_r <= prod_s;
        end
    end

    // Operand shifters, accumulator and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= {PW{1'b0}};
            b_sh_r  <= {DATA_WIDTH{1'b0}};
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {GW{1'b0}};
            grade_r <= {GW{1'b0}};
        end else if (!enable) begin
            a_sh_r  <= {PW{1'b0}};
            b_sh_r  <= {DATA_WIDTH{1'b0}};
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {GW{1'b0}};
            grade_r <= {GW{1'b0}};
        end else if (accept_s) begin
            a_sh_r  <= {{DATA_WIDTH{1'b0}}, a & grade_mask(polyn_grade)};
            b_sh_r  <= b & grade_mask(polyn_grade);
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {GW{1'b0}};
            grade_r <= polyn_grade;
        end else if (state_r == RUN) begin
            // a is pre-shifted so step k XORs in a << (k-1) without a barrel shifter.
            a_sh_r  <= a_sh_r << 1;
            b_sh_r  <= b_sh_r >> 1;
            acc_r   <= acc_step_s;
            cnt_r   <= cnt_r + GW'(1);
            grade_r <= grade_r;
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            acc_r   <= acc_r;
            cnt_r   <= cnt_r;
            grade_r <= grade_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign prod = prod_r;

endmodule

// File: tb/tb_cl_mult_seq.sv
// Directed bench for cl_mult_seq (DATA_WIDTH=4) with hand-computed products.
module tb_cl_mult_seq;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       start;
    logic [2:0] polyn_grade;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] prod;

    int n_chk;
    int n_bad;

    cl_mult_seq #(.DATA_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .polyn_grade(polyn_grade), .a(a), .b(b),
        .busy(busy), .done(done), .prod(prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start pulse; returns just after the accepting edge E0.
    task automatic start_op(input logic [2:0] g, input logic [3:0] va, input logic [3:0] vb);
        polyn_grade = g;
        a           = va;
        b           = vb;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        polyn_grade = 3'd4;
        a = 4'h0;
        b = 4'h0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_prod", int'(prod), 0);
        tick();
        rst_n = 1'b1;

        // 1011 * 0110 = 111010
        start_op(3'd4, 4'b1011, 4'b0110);
        chk("t1_busy_e0", int'(busy), 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_busy_run", int'(busy), 1);
            chk("t1_done_run", int'(done), 0);
            chk("t1_prod_run", int'(prod), 0);
        end
        tick();
        chk("t1_done", int'(done), 1);
        chk("t1_busy_done", int'(busy), 0);
        chk("t1_prod", int'(prod), 8'h3A);
        tick();
        chk("t1_done_pulse", int'(done), 0);
        chk("t1_prod_hold", int'(prod), 8'h3A);

        // Illegal grade 1: straight to DONE with prod cleared, never busy
        start_op(3'd1, 4'hF, 4'hF);
        chk("g1_busy", int'(busy), 0);
        chk("g1_done", int'(done), 1);
        chk("g1_prod", int'(prod), 0);
        tick();
        chk("g1_done_end", int'(done), 0);

        // F*F = 0x55, then back-to-back 3*3 = 0x05 started in the done cycle
        start_op(3'd4, 4'hF, 4'hF);
        repeat (4) tick();
        chk("t2_done", int'(done), 1);
        chk("t2_prod", int'(prod), 8'h55);
        start_op(3'd4, 4'h3, 4'h3);
        chk("t2b_busy", int'(busy), 1);
        chk("t2b_prod_held", int'(prod), 8'h55);
        polyn_grade = 3'd2;
        a = 4'hF;
        b = 4'hF;
        repeat (3) tick();
        chk("t2b_done_early", int'(done), 0);
        chk("t2b_prod_run", int'(prod), 8'h55);
        tick();
        chk("t2b_done", int'(done), 1);
        chk("t2b_prod", int'(prod), 8'h05);

        // Grade 3 masking: 111 * 101 = 11011
        start_op(3'd3, 4'hF, 4'hD);
        repeat (2) tick();
        chk("t3_done_early", int'(done), 0);
        tick();
        chk("t3_done", int'(done), 1);
        chk("t3_prod", int'(prod), 8'h1B);
        chk("t3_top_bits", int'(prod[7:6]), 0);

        // Illegal grade 5
        tick();
        start_op(3'd5, 4'hF, 4'hF);
        chk("g5_busy", int'(busy), 0);
        chk("g5_done", int'(done), 1);
        chk("g5_prod", int'(prod), 0);
        tick();

        // start re-pulsed at E0+2 with a=0 is ignored
        start_op(3'd4, 4'b1011, 4'b0110);
        tick();
        start = 1'b1;
        a = 4'h0;
        tick();
        start = 1'b0;
        tick();
        chk("t5_done_early", int'(done), 0);
        tick();
        chk("t5_done", int'(done), 1);
        chk("t5_prod", int'(prod), 8'h3A);
        tick();

        // Reset at E0+2 aborts without a done pulse
        start_op(3'd4, 4'hF, 4'hF);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("r_prod", int'(prod), 0);
        chk("r_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            chk("r_no_done", int'(done), 0);
            tick();
        end
        start_op(3'd4, 4'b1011, 4'b0110);
        chk("r_restart_busy", int'(busy), 1);
        repeat (4) tick();
        chk("r_restart_prod", int'(prod), 8'h3A);

        // enable low mid-run clears outputs; start ignored while low
        start_op(3'd4, 4'hF, 4'hF);
        tick();
        enable = 1'b0;
        tick();
        chk("en_prod", int'(prod), 0);
        chk("en_busy", int'(busy), 0);
        chk("en_done", int'(done), 0);
        start = 1'b1;
        repeat (2) begin
            tick();
            chk("en_start_busy", int'(busy), 0);
            chk("en_start_done", int'(done), 0);
        end
        start = 1'b0;
        enable = 1'b1;
        tick();
        chk("en_idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
